reg_dst_pipe: RTL

- Parametrised successor to the 5-bit 2-to-1 register-destination mux.
- Selects the write-back destination from rt, rd or a fixed link register (JAL), per instruction.
- Carries the selected destination and its valid bit through DEPTH pipeline stages (EX..WB), with stall and flush.
- Provides per-stage match flags against the decode-stage source registers for the hazard/forwarding unit.

---
 rtl/reg_dst_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/reg_dst_pipe.sv
// reg_dst_pipe
//   Picks the write-back destination register (rt, rd or the link register)
//   for the decoding instruction. It then carries that destination and its
//   write-valid bit through DEPTH pipeline stages, with stall and flush.
//   It also flags every stage whose valid destination matches a decode-stage
//   source register, for use by the hazard/forwarding unit.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   rt_in, rd_in  rt / rd fields of the decoding instruction
//   dst_sel       00 rt, 01 rd, 10 LINK_REG, 11 rt (reserved)
//   reg_write_in  decoding instruction writes a register
//   stall         hold stage 0, bubble into stage 1
//   flush         bubble into stage 0 and stage 1 (wins over stall)
//   src_a, src_b  rs / rt of the decoding instruction
//   dst_out       per-stage destination, stage i at [i*ADDR_W +: ADDR_W]
//   valid_out     per-stage write-valid
//   hit_a, hit_b  per-stage valid destination match against src_a / src_b
//   wb_dst, wb_we last (write-back) stage destination and valid
module reg_dst_pipe #(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int LINK_REG = 31
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        rt_in,
   input  logic [ADDR_W-1:0]        rd_in,
   input  logic [1:0]               dst_sel,
   input  logic                     reg_write_in,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        src_a,
   input  logic [ADDR_W-1:0]        src_b,
   output logic [DEPTH*ADDR_W-1:0]  dst_out,
   output logic [DEPTH-1:0]         valid_out,
   output logic [DEPTH-1:0]         hit_a,
   output logic [DEPTH-1:0]         hit_b,
   output logic [ADDR_W-1:0]        wb_dst,
   output logic                     wb_we
);

   localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

   logic [DEPTH-1:0][ADDR_W-1:0] dst_q, dst_d;
   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [ADDR_W-1:0]            sel_dst;
   logic                         sel_valid;

   always_comb begin
      sel_dst = rt_in;
      unique case (dst_sel)
         2'b01:   sel_dst = rd_in;
         2'b10:   sel_dst = LINK;
         default: sel_dst = rt_in;
      endcase
      // Register 0 is hard-wired; a write to it must never look like a hazard.
      sel_valid = reg_write_in && (sel_dst != '0);
   end

   always_comb begin
      dst_d = dst_q;
      vld_d = vld_q;
      // Stage 0: flush kills the incoming instruction, stall holds the current one.
      if (flush) begin
         dst_d[0] = '0;
         vld_d[0] = 1'b0;
      end else if (!stall) begin
         dst_d[0] = sel_dst;
         vld_d[0] = sel_valid;
      end
      // Stage 1 takes a bubble whenever stage 0 does not hand off
      // (stall) or its occupant is killed (flush). Older stages always drain.
      for (int i = 1; i < DEPTH; i++) begin
         if (i == 1 && (stall || flush)) begin
            dst_d[i] = '0;
            vld_d[i] = 1'b0;
         end else begin
            dst_d[i] = dst_q[i-1];
            vld_d[i] = vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dst_q <= '0;
         vld_q <= '0;
      end else begin
         dst_q <= dst_d;
         vld_q <= vld_d;
      end
   end

   assign dst_out   = dst_q;
   assign valid_out = vld_q;
   assign wb_dst    = dst_q[DEPTH-1];
   assign wb_we     = vld_q[DEPTH-1];

   // Valid entries never hold register 0, so src == 0 cannot produce a hit.
   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      assign hit_a[g] = vld_q[g] && (dst_q[g] == src_a);
      assign hit_b[g] = vld_q[g] && (dst_q[g] == src_b);
   end

endmodule
